// File: rtl/menu_char_render.sv
// Text-box overlay for a VGA stream: addresses an external text/font ROM pair and
// paints lit glyph pixels over the background, with a fixed 4-cycle pipeline.
module menu_char_render #(
    parameter logic [10:0] XPOS       = 11'd448,
    parameter logic [10:0] YPOS       = 11'd256,
    parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixels,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        ib;
        logic [2:0]  px;
    } pix_t;

    pix_t        pipe_q [3];
    pix_t        pipe0_d;
    logic [6:0]  hrel;
    logic [7:0]  vrel;
    logic        in_box;
    logic        glyph;
    logic [7:0]  char_xy_q, char_xy_d;
    logic [3:0]  char_line_q, char_line_d;
    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        // Only the low bits of the offsets are ever used, so narrow subtraction suffices.
        hrel   = hcount_in[6:0] - XPOS[6:0];
        vrel   = vcount_in[7:0] - YPOS[7:0];
        in_box = ({1'b0, hcount_in} >= {1'b0, XPOS}) &&
                 ({1'b0, hcount_in} <  ({1'b0, XPOS} + 12'd128)) &&
                 ({1'b0, vcount_in} >= {1'b0, YPOS}) &&
                 ({1'b0, vcount_in} <  ({1'b0, YPOS} + 12'd256));

        pipe0_d = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
                    hb: hblnk_in, vb: vblnk_in, rgb: rgb_in, ib: in_box, px: hrel[2:0]};

        char_xy_d   = in_box ? {vrel[7:4], hrel[6:3]} : 8'd0;
        char_line_d = in_box ? vrel[3:0] : 4'd0;

        glyph = char_pixels[3'd7 - pipe_q[2].px];
        rgb_d = (pipe_q[2].ib && !pipe_q[2].hb && !pipe_q[2].vb && glyph) ? TEXT_COLOR
                                                                         : pipe_q[2].rgb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe_q[i] <= '0;
            char_xy_q   <= 8'd0;
            char_line_q <= 4'd0;
            hcount_q    <= 11'd0;
            vcount_q    <= 11'd0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            rgb_q       <= 12'd0;
        end else begin
            pipe_q[0]   <= pipe0_d;
            pipe_q[1]   <= pipe_q[0];
            pipe_q[2]   <= pipe_q[1];
            char_xy_q   <= char_xy_d;
            char_line_q <= char_line_d;
            hcount_q    <= pipe_q[2].h;
            vcount_q    <= pipe_q[2].v;
            hsync_q     <= pipe_q[2].hs;
            vsync_q     <= pipe_q[2].vs;
            hblnk_q     <= pipe_q[2].hb;
            vblnk_q     <= pipe_q[2].vb;
            rgb_q       <= rgb_d;
        end
    end

    assign char_xy    = char_xy_q;
    assign char_line  = char_line_q;
    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign hblnk_out  = hblnk_q;
    assign vblnk_out  = vblnk_q;
    assign rgb_out    = rgb_q;

endmodule
